// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// RV32M funct3 encodings, control state encoding and operand signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL keeps the low half, which is identical for signed and unsigned operands.
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, fixed XLEN-cycle latency.
// A single add/sub datapath serves both shift-add multiply and restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]   X_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   X_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   X_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] P_ONE    = {{(2*XLEN-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   hi_r, lo_r, mcand_r;
    logic [XLEN-1:0]   spec_val_r, result_r;
    logic [2:0]        op_r;
    logic              neg_r, spec_r, zero_r;

    logic              accept_s, last_s;
    logic              neg_a_s, neg_b_s, neg_now_s, spec_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, spec_val_s;
    logic [XLEN:0]     add_a_s, add_b_s, add_sum_s;
    logic              sub_s;
    logic [XLEN-1:0]   hi_nxt_s, lo_nxt_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0]   q_fix_s, r_fix_s, final_s;

    assign accept_s  = in_valid && (state_r == ST_IDLE);
    assign last_s    = (state_r == ST_CALC) && (cnt_r == CNT_ONE);
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign result    = result_r;
    assign zero      = zero_r;

    // Operand magnitudes, result sign and special-case override, evaluated on the live inputs
    always_comb begin
        neg_a_s    = a_is_signed(op) & a[XLEN-1];
        neg_b_s    = b_is_signed(op) & b[XLEN-1];
        mag_a_s    = neg_a_s ? (~a + X_ONE) : a;
        mag_b_s    = neg_b_s ? (~b + X_ONE) : b;
        neg_now_s  = 1'b0;
        spec_s     = 1'b0;
        spec_val_s = X_ZERO;
        // The remainder follows the dividend's sign; everything else uses the xor of both
        if (op == OP_REM) begin
            neg_now_s = neg_a_s;
        end else begin
            neg_now_s = neg_a_s ^ neg_b_s;
        end
        if (op[2] && (b == X_ZERO)) begin
            spec_s     = 1'b1;
            spec_val_s = op[1] ? a : X_ONES;
        end else if ((op == OP_DIV) && (a == X_MIN) && (b == X_ONES)) begin
            spec_s     = 1'b1;
            spec_val_s = X_MIN;
        end else if ((op == OP_REM) && (a == X_MIN) && (b == X_ONES)) begin
            spec_s     = 1'b1;
            spec_val_s = X_ZERO;
        end else begin
            spec_s     = 1'b0;
            spec_val_s = X_ZERO;
        end
    end

    // Shared adder: adds the multiplicand for multiply, subtracts the divisor for divide
    always_comb begin
        add_a_s = {(XLEN+1){1'b0}};
        add_b_s = {(XLEN+1){1'b0}};
        sub_s   = 1'b0;
        if (op_r[2]) begin
            add_a_s = {hi_r, lo_r[XLEN-1]};
            add_b_s = ~{1'b0, mcand_r};
            sub_s   = 1'b1;
        end else begin
            add_a_s = {1'b0, hi_r};
            add_b_s = {1'b0, mcand_r};
            sub_s   = 1'b0;
        end
        add_sum_s = add_a_s + add_b_s + {{XLEN{1'b0}}, sub_s};
    end

    // One iteration step: shift-right-with-add or shift-left-with-trial-subtract
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        if (op_r[2]) begin
            if (add_sum_s[XLEN]) begin
                hi_nxt_s = add_a_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
            end else begin
                hi_nxt_s = add_sum_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
            end
        end else begin
            if (lo_r[0]) begin
                {hi_nxt_s, lo_nxt_s} = {add_sum_s, lo_r[XLEN-1:1]};
            end else begin
                {hi_nxt_s, lo_nxt_s} = {1'b0, hi_r, lo_r[XLEN-1:1]};
            end
        end
    end

    // Sign correction and op selection applied to the final iteration's output
    always_comb begin
        prod_s     = {hi_nxt_s, lo_nxt_s};
        prod_fix_s = neg_r ? (~prod_s + P_ONE) : prod_s;
        q_fix_s    = neg_r ? (~lo_nxt_s + X_ONE) : lo_nxt_s;
        r_fix_s    = neg_r ? (~hi_nxt_s + X_ONE) : hi_nxt_s;
        final_s    = X_ZERO;
        case (op_r)
            OP_MUL:                        final_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_s = q_fix_s;
            OP_REM, OP_REMU:               final_s = r_fix_s;
            default:                       final_s = X_ZERO;
        endcase
        if (spec_r) begin
            final_s = spec_val_r;
        end else begin
            final_s = final_s;
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; a result handshake never overlaps with an accept
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nxt = ST_CALC;
                else          state_nxt = ST_IDLE;
            end
            ST_CALC: begin
                if (cnt_r == CNT_ONE) state_nxt = ST_DONE;
                else                  state_nxt = ST_CALC;
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
                else           state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers: latch at accept, iterate in CALC, load result on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            hi_r       <= X_ZERO;
            lo_r       <= X_ZERO;
            mcand_r    <= X_ZERO;
            op_r       <= 3'b000;
            neg_r      <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= X_ZERO;
            result_r   <= X_ZERO;
            zero_r     <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= CNT_INIT;
            hi_r       <= X_ZERO;
            lo_r       <= mag_a_s;
            mcand_r    <= mag_b_s;
            op_r       <= op;
            neg_r      <= neg_now_s;
            spec_r     <= spec_s;
            spec_val_r <= spec_val_s;
        end else if (state_r == ST_CALC) begin
            cnt_r <= cnt_r - CNT_ONE;
            hi_r  <= hi_nxt_s;
            lo_r  <= lo_nxt_s;
            if (last_s) begin
                result_r <= final_s;
                zero_r   <= (final_s == X_ZERO);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit at XLEN=32 and XLEN=16,
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, or32, z32, bz32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        iv16, ir16, ov16, or16, z16, bz16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, res16;

    muldiv_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(or32), .result(res32), .zero(z32), .busy(bz32)
    );

    muldiv_unit #(.XLEN(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .result(res16), .zero(z16), .busy(bz16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int w);  return (w == 32) ? ir32 : ir16; endfunction
    function automatic logic get_valid(input int w);  return (w == 32) ? ov32 : ov16; endfunction
    function automatic logic get_busy(input int w);   return (w == 32) ? bz32 : bz16; endfunction
    function automatic logic get_zero(input int w);   return (w == 32) ? z32  : z16;  endfunction
    function automatic logic [31:0] get_result(input int w);
        return (w == 32) ? res32 : {16'h0000, res16};
    endfunction

    task automatic drive(input int w, input logic v, input logic [2:0] o,
                         input logic [31:0] av, input logic [31:0] bv);
        if (w == 32) begin iv32 = v; op32 = o; a32 = av; b32 = bv; end
        else         begin iv16 = v; op16 = o; a16 = av[15:0]; b16 = bv[15:0]; end
    endtask

    task automatic set_ready(input int w, input logic v);
        if (w == 32) or32 = v; else or16 = v;
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input int w, input logic [2:0] o,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, p, r;
        longint      sa, sb, t;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'h0, a} & mask;
        ub   = {32'h0, b} & mask;
        sa   = ua[w-1] ? ($signed(ua) - $signed(64'd1 << w)) : $signed(ua);
        sb   = ub[w-1] ? ($signed(ub) - $signed(64'd1 << w)) : $signed(ub);
        r    = 64'd0;
        case (o)
            OP_MUL:    begin t = sa * sb;           p = t; r = p & mask; end
            OP_MULH:   begin t = sa * sb;           p = t; r = (p >> w) & mask; end
            OP_MULHSU: begin t = sa * $signed(ub);  p = t; r = (p >> w) & mask; end
            OP_MULHU:  begin p = ua * ub;                  r = (p >> w) & mask; end
            OP_DIV: begin
                if (ub == 64'd0) r = mask;
                else if (sa == -(64'sd1 <<< (w-1)) && sb == -64'sd1) r = ua;
                else begin t = sa / sb; p = t; r = p & mask; end
            end
            OP_DIVU:   r = (ub == 64'd0) ? mask : (ua / ub);
            OP_REM: begin
                if (ub == 64'd0) r = ua;
                else if (sa == -(64'sd1 <<< (w-1)) && sb == -64'sd1) r = 64'd0;
                else begin t = sa % sb; p = t; r = p & mask; end
            end
            OP_REMU:   r = (ub == 64'd0) ? ua : (ua % ub);
            default:   r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    // Issue one op, scramble inputs during CALC, check latency/result, optionally stall DONE
    task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp, input int hold,
                          input string tag);
        int cnt;
        @(negedge clk);
        check_val({tag, "/in_ready"}, get_ready(w), 1'b1);
        drive(w, 1'b1, o, av, bv);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 3'($urandom), $urandom, $urandom);
        check_val({tag, "/busy"}, get_busy(w), 1'b1);
        cnt = 1;
        while (!get_valid(w) && cnt < 3 * w) begin
            @(negedge clk);
            cnt++;
        end
        check_val({tag, "/latency"}, cnt, w + 1);
        check_val({tag, "/result"}, get_result(w), exp);
        check_val({tag, "/zero"}, get_zero(w), exp == 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val({tag, "/hold_result"}, get_result(w), exp);
            check_val({tag, "/hold_in_ready"}, get_ready(w), 1'b0);
            check_val({tag, "/hold_valid"}, get_valid(w), 1'b1);
        end
        set_ready(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(w, 1'b0);
        check_val({tag, "/released"}, {get_valid(w), get_ready(w)}, 2'b01);
    endtask

    logic [2:0]  d_op [12] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                               OP_DIVU, OP_REMU, OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] d_a  [12] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'd100, 32'd1234, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] d_b  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_e  [12] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

    initial begin
        int          w, cnt, seen;
        logic [2:0]  o;
        logic [31:0] av, bv, ev, mask;

        rst = 1'b1;
        drive(32, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(16, 1'b0, 3'b000, 32'h0, 32'h0);
        or32 = 1'b0;
        or16 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset32", {ir32, ov32, bz32, z32, res32}, {4'b1000, 32'h0});
        check_val("reset16", {ir16, ov16, bz16, z16, res16}, {4'b1000, 16'h0});
        rst = 1'b0;

        // Abort a MUL mid-calculation with reset
        @(negedge clk);
        drive(32, 1'b1, OP_MUL, 32'd7, 32'd9);
        @(posedge clk);
        @(negedge clk);
        drive(32, 1'b0, OP_MUL, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        check_val("abort/busy_before", bz32, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("abort/idle", {ir32, bz32, ov32}, 3'b100);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov32) seen++;
        end
        check_val("abort/no_valid", seen, 0);

        // Directed cases at both widths; the first MUL also stalls in DONE for 10 cycles
        for (int wi = 0; wi < 2; wi++) begin
            w = (wi == 0) ? 32 : 16;
            for (int i = 0; i < 12; i++) begin
                if (w == 32) begin
                    av = d_a[i]; bv = d_b[i]; ev = d_e[i];
                end else begin
                    av = (d_a[i] == 32'h80000000) ? 32'h8000 : (d_a[i] & 32'hFFFF);
                    bv = d_b[i] & 32'hFFFF;
                    ev = (d_e[i] == 32'h80000000) ? 32'h8000 : (d_e[i] & 32'hFFFF);
                end
                run_op(w, d_op[i], av, bv, ev, (i == 0) ? 10 : 0, $sformatf("dir%0d_%0d", w, i));
            end
        end

        // Result handshake coincides with a new request: accepted only after IDLE is reached
        @(negedge clk);
        drive(32, 1'b1, OP_DIVU, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        drive(32, 1'b0, OP_MUL, 32'd0, 32'd0);
        cnt = 1;
        while (!ov32 && cnt < 100) begin @(negedge clk); cnt++; end
        check_val("b2b/first_latency", cnt, 33);
        check_val("b2b/first_result", res32, 32'd14);
        drive(32, 1'b1, OP_MUL, 32'd7, 32'hFFFFFFFD);
        or32 = 1'b1;
        check_val("b2b/no_ready_in_done", ir32, 1'b0);
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;
        check_val("b2b/idle_gap", {ov32, ir32, bz32}, 3'b010);
        @(posedge clk);
        @(negedge clk);
        drive(32, 1'b0, OP_DIV, 32'd0, 32'd0);
        check_val("b2b/accepted", bz32, 1'b1);
        cnt = 1;
        while (!ov32 && cnt < 100) begin @(negedge clk); cnt++; end
        check_val("b2b/second_latency", cnt, 33);
        check_val("b2b/second_result", res32, 32'hFFFFFFEB);
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;

        // Random ops biased towards divide special cases and small operands
        for (int wi = 0; wi < 2; wi++) begin
            w    = (wi == 0) ? 32 : 16;
            mask = (w == 32) ? 32'hFFFFFFFF : 32'h0000FFFF;
            for (int k = 0; k < 120; k++) begin
                o  = 3'($urandom_range(0, 7));
                av = $urandom & mask;
                bv = $urandom & mask;
                case ($urandom_range(0, 9))
                    0:       bv = 32'h0;
                    1:       begin av = 32'h1 << (w - 1); bv = mask; end
                    2:       begin av = $urandom_range(0, 300); bv = $urandom_range(1, 20); end
                    3:       bv = (32'h0 - 32'($urandom_range(1, 9))) & mask;
                    default: av = av;
                endcase
                ev = ref_model(w, o, av, bv);
                run_op(w, o, av, bv, ev, $urandom_range(0, 2), $sformatf("rnd%0d_%0d_op%0d", w, k, o));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
